alu_decode_stage: RTL

- Issue stage directly upstream of the 32-bit ALU (4-bit operation code = {funct7[5], funct3}).
- Accepts one RV32I ALU instruction per cycle (OP and OP-IMM opcodes) and decodes it.
- Reads the integrated 32x32 register file and tracks outstanding destination writes in a scoreboard.
- Presents registered operand1/operand2/operation/rd to the ALU over a valid/ready handshake. Writeback returns through the wb_* port.

---
 rtl/alu_decode_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
// Decode/issue stage in front of the 32-bit ALU: RV32I OP/OP-IMM decode, register file, write scoreboard.
// Latency: 1 cycle from accept to out_valid. Backpressure: out_ready low holds the output register and drops in_ready.
// A pending source or destination (RAW/WAW) also drops in_ready until its writeback arrives.
module alu_decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_operand1,
    output logic [XLEN-1:0] out_operand2,
    output logic [3:0]      out_operation,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;

    logic            dec_legal;
    logic            use_rs1, use_rs2, is_imm;
    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_imm;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] sb_q, sb_d;
    logic [NREGS-1:0] clr_vec, live_sb;
    logic             wb_clr;

    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            hazard, accept;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_operand1_q, out_operand1_d;
    logic [XLEN-1:0] out_operand2_q, out_operand2_d;
    logic [3:0]      out_operation_q, out_operation_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_illegal_q, out_illegal_d;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    always_comb begin
        dec_legal = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_imm    = 1'b0;
        dec_op    = 4'b0000;
        dec_imm   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        if (opcode == OPC_OP && funct3 != 3'b010 && funct3 != 3'b011) begin
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            dec_op    = {in_instr[30], funct3};
            dec_legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        end else if (opcode == OPC_OPIMM && funct3 != 3'b010 && funct3 != 3'b011) begin
            use_rs1 = 1'b1;
            is_imm  = 1'b1;
            case (funct3)
                3'b101: begin
                    dec_op    = {in_instr[30], 3'b101};
                    dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
                3'b001: begin
                    dec_op    = 4'b0001;
                    dec_legal = (funct7 == 7'b0000000);
                end
                // bit 30 is immediate data here, so ADDI can never turn into SUB
                default: begin
                    dec_op    = {1'b0, funct3};
                    dec_legal = 1'b1;
                end
            endcase
        end
    end

    // Write-through read: a writeback landing this cycle is visible immediately
    always_comb begin
        wb_clr  = wb_en && (wb_rd != 5'd0);
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) rs1_val = (wb_clr && wb_rd == rs1) ? wb_data : regs_q[rs1];
        if (rs2 != 5'd0) rs2_val = (wb_clr && wb_rd == rs2) ? wb_data : regs_q[rs2];
    end

    always_comb begin
        clr_vec = wb_clr ? (NREGS'(1) << wb_rd) : '0;
        live_sb = sb_q & ~clr_vec;
        hazard  = dec_legal && ((use_rs1 && live_sb[rs1]) ||
                                (use_rs2 && live_sb[rs2]) ||
                                live_sb[rd]);
        in_ready = (!out_valid_q || out_ready) && !hazard;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_clr) regs_d[wb_rd] = wb_data;
        // set after clear so a same-cycle issue to the same rd keeps it pending
        sb_d = sb_q & ~clr_vec;
        if (accept && dec_legal && rd != 5'd0) sb_d[rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d     = out_valid_q;
        out_operand1_d  = out_operand1_q;
        out_operand2_d  = out_operand2_q;
        out_operation_d = out_operation_q;
        out_rd_d        = out_rd_q;
        out_illegal_d   = out_illegal_q;
        if (accept) begin
            out_valid_d     = 1'b1;
            out_operand1_d  = dec_legal ? rs1_val : '0;
            out_operand2_d  = dec_legal ? (is_imm ? dec_imm : rs2_val) : '0;
            out_operation_d = dec_legal ? dec_op : 4'b0000;
            out_rd_d        = dec_legal ? rd : 5'd0;
            out_illegal_d   = !dec_legal;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            sb_q            <= '0;
            out_valid_q     <= 1'b0;
            out_operand1_q  <= '0;
            out_operand2_q  <= '0;
            out_operation_q <= 4'b0000;
            out_rd_q        <= 5'd0;
            out_illegal_q   <= 1'b0;
        end else begin
            regs_q          <= regs_d;
            sb_q            <= sb_d;
            out_valid_q     <= out_valid_d;
            out_operand1_q  <= out_operand1_d;
            out_operand2_q  <= out_operand2_d;
            out_operation_q <= out_operation_d;
            out_rd_q        <= out_rd_d;
            out_illegal_q   <= out_illegal_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_operand1  = out_operand1_q;
    assign out_operand2  = out_operand2_q;
    assign out_operation = out_operation_q;
    assign out_rd        = out_rd_q;
    assign out_illegal   = out_illegal_q;

endmodule
